// File: rtl/stopwatch_bcd_counter_pkg.sv
// Shared definitions for the stopwatch BCD counter: state encoding,
// BCD digit limits and default timing parameters.
package stopwatch_bcd_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX_DEC      = 4'd9;
  localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

  // 100 MHz clk_sys -> 100 Hz hundredth-second tick
  localparam int unsigned DEF_TICK_DIV    = 1000000;
  localparam int unsigned DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/stopwatch_bcd_counter_digit.sv
// One BCD digit with a settable rollover value. The carry is combinational
// so a chain of these ripples an increment through in the same cycle.
module bcd_digit_counter #(
  parameter logic [3:0] MAX = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] q,
  output logic       carry
);

  logic [3:0] r_q;

  assign carry = inc && (r_q == MAX);
  assign q     = r_q;

  // Digit register: clear wins over increment, rolls MAX -> 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 4'd0;
    end else if (clr) begin
      r_q <= 4'd0;
    end else if (inc) begin
      r_q <= (r_q == MAX) ? 4'd0 : r_q + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch core: button synchronisers and edge detectors, IDLE/RUN/PAUSE
// control, hundredth-second prescaler, 00.00..59.99 BCD count and lap freeze.
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_IDLE  | cleared, count 00.00, prescaler held at 0
//  ST_RUN   | prescaler running, count advances on each tick
//  ST_PAUSE | count and prescaler phase held, resume continues period
module stopwatch_bcd_counter
  import stopwatch_bcd_counter_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  output logic [3:0] digit_0,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic       running,
  output logic       lap_active,
  output logic       wrap
);

  localparam int unsigned         PW         = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]       PRESC_LAST = PW'(TICK_DIV - 1);

  // Button bit order throughout: {lap, clear, start_stop}
  logic [2:0]                    w_btn;
  logic [SYNC_STAGES-1:0][2:0]   r_sync;
  logic [2:0]                    r_sync_prev;
  logic [2:0]                    r_evt;

  logic                          w_evt_ss;
  logic                          w_evt_clr;
  logic                          w_evt_lap;

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic                          w_run;
  logic                          w_tick;

  logic [PW-1:0]                 r_presc;

  logic [3:0]                    w_inc;
  logic [3:0]                    w_carry;
  logic [3:0]                    w_q0, w_q1, w_q2, w_q3;
  logic [15:0]                   w_count;

  logic                          r_lap_active;
  logic [15:0]                   r_lap;
  logic                          r_wrap;

  assign w_btn = {btn_lap, btn_clear, btn_start_stop};

  // Synchronise each button and register a one-cycle rising-edge event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync      <= '0;
      r_sync_prev <= 3'b000;
      r_evt       <= 3'b000;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], w_btn};
      r_sync_prev <= r_sync[SYNC_STAGES-1];
      r_evt       <= r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    end
  end

  // Priority clear > start_stop > lap; losers in the same cycle are dropped.
  assign w_evt_clr = r_evt[1];
  assign w_evt_ss  = r_evt[0] && !w_evt_clr;
  assign w_evt_lap = r_evt[2] && !w_evt_clr && !r_evt[0];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and tick decode.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = (r_state == ST_RUN);
    w_tick      = w_run && (r_presc == PRESC_LAST);
    if (w_evt_clr) begin
      w_state_nxt = ST_IDLE;
    end else if (w_evt_ss) begin
      unique case (r_state)
        ST_IDLE:  w_state_nxt = ST_RUN;
        ST_RUN:   w_state_nxt = ST_PAUSE;
        ST_PAUSE: w_state_nxt = ST_RUN;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Prescaler: runs only in RUN, keeps its phase through PAUSE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
    end else if (w_evt_clr || (r_state == ST_IDLE)) begin
      r_presc <= '0;
    end else if (w_run) begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);
    end
  end

  // A tick in the same cycle as start_stop still counts; clear beats it.
  assign w_inc = {w_carry[2], w_carry[1], w_carry[0], w_tick && !w_evt_clr};

  bcd_digit_counter #(.MAX(BCD_MAX_DEC)) u_hund_ones (
    .clk(clk), .rst(rst), .clr(w_evt_clr), .inc(w_inc[0]), .q(w_q0), .carry(w_carry[0])
  );
  bcd_digit_counter #(.MAX(BCD_MAX_DEC)) u_hund_tens (
    .clk(clk), .rst(rst), .clr(w_evt_clr), .inc(w_inc[1]), .q(w_q1), .carry(w_carry[1])
  );
  bcd_digit_counter #(.MAX(BCD_MAX_DEC)) u_sec_ones (
    .clk(clk), .rst(rst), .clr(w_evt_clr), .inc(w_inc[2]), .q(w_q2), .carry(w_carry[2])
  );
  bcd_digit_counter #(.MAX(BCD_MAX_SEC_TENS)) u_sec_tens (
    .clk(clk), .rst(rst), .clr(w_evt_clr), .inc(w_inc[3]), .q(w_q3), .carry(w_carry[3])
  );

  assign w_count = {w_q3, w_q2, w_q1, w_q0};

  // Wrap pulse lands on the same edge as the 59.99 -> 00.00 rollover.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_carry[3];
    end
  end

  // Lap freeze: capture the pre-tick count when lap mode is entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lap_active <= 1'b0;
      r_lap        <= 16'h0000;
    end else if (w_evt_clr) begin
      r_lap_active <= 1'b0;
      r_lap        <= 16'h0000;
    end else if (w_evt_lap) begin
      if (r_state == ST_RUN) begin
        r_lap_active <= !r_lap_active;
        if (!r_lap_active) begin
          r_lap <= w_count;
        end
      end else if ((r_state == ST_PAUSE) && r_lap_active) begin
        r_lap_active <= 1'b0;
      end
    end
  end

  assign {digit_3, digit_2, digit_1, digit_0} = r_lap_active ? r_lap : w_count;
  assign running    = w_run;
  assign lap_active = r_lap_active;
  assign wrap       = r_wrap;

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for the stopwatch counter with TICK_DIV=4, SYNC_STAGES=2.
// A button rise lands as a state change on the fourth clock edge after it.
module tb_stopwatch_bcd_counter;

  logic       clk;
  logic       rst;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [3:0] digit_0, digit_1, digit_2, digit_3;
  logic       running;
  logic       lap_active;
  logic       wrap;

  int n_tests = 0;
  int n_fail  = 0;

  stopwatch_bcd_counter #(.TICK_DIV(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .digit_0(digit_0), .digit_1(digit_1), .digit_2(digit_2), .digit_3(digit_3),
    .running(running), .lap_active(lap_active), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] digits();
    return {digit_3, digit_2, digit_1, digit_0};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then sit 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    step(3);
    check("rst_digits",  digits(),          16'h0000);
    check("rst_running", {15'd0, running},    16'd0);
    check("rst_lap",     {15'd0, lap_active}, 16'd0);
    check("rst_wrap",    {15'd0, wrap},       16'd0);
    rst = 1'b1;
    step(2);

    // Start latency and first ten ticks, button held throughout
    btn_start_stop = 1'b1;
    step(3);
    check("start_lat_early", {15'd0, running}, 16'd0);
    step(1);
    check("start_lat",       {15'd0, running}, 16'd1);
    step(40);
    check("ten_ticks",  digits(),          16'h0010);
    check("held_once",  {15'd0, running},  16'd1);
    btn_start_stop = 1'b0;

    // Roll over 59.99 -> 00.00
    step(5989 * 4);
    check("at_5999",      digits(),         16'h5999);
    check("no_wrap_yet",  {15'd0, wrap},    16'd0);
    step(3);
    check("hold_5999",    digits(),         16'h5999);
    step(1);
    check("wrap_digits",  digits(),         16'h0000);
    check("wrap_pulse",   {15'd0, wrap},    16'd1);
    check("wrap_running", {15'd0, running}, 16'd1);
    step(1);
    check("wrap_one_cyc", {15'd0, wrap},    16'd0);

    // Clear (a tick lands just before it, clear still zeroes)
    btn_clear = 1'b1;
    step(4);
    check("clr_digits",  digits(),          16'h0000);
    check("clr_running", {15'd0, running},  16'd0);
    btn_clear = 1'b0;
    step(2);

    // Pause at 00.25, resume keeps prescaler phase
    btn_start_stop = 1'b1;
    step(4);
    check("start2", {15'd0, running}, 16'd1);
    btn_start_stop = 1'b0;
    step(98);
    check("at_0024", digits(), 16'h0024);
    btn_start_stop = 1'b1;
    step(4);
    check("pause_running", {15'd0, running}, 16'd0);
    check("pause_digits",  digits(),         16'h0025);
    btn_start_stop = 1'b0;
    step(100);
    check("pause_hold",    digits(),         16'h0025);
    btn_start_stop = 1'b1;
    step(4);
    check("resume_running", {15'd0, running}, 16'd1);
    btn_start_stop = 1'b0;
    step(1);
    check("resume_pre",  digits(), 16'h0025);
    step(1);
    check("resume_0026", digits(), 16'h0026);

    // start_stop coinciding with a tick: tick applied, then pause
    btn_start_stop = 1'b1;
    step(4);
    check("ss_tick_running", {15'd0, running}, 16'd0);
    check("ss_tick_digits",  digits(),         16'h0027);
    btn_start_stop = 1'b0;
    step(8);
    check("ss_tick_hold",    digits(),         16'h0027);

    // Lap: entering coincides with a tick, captures pre-tick 00.07
    btn_clear = 1'b1;
    step(4);
    btn_clear = 1'b0;
    step(2);
    btn_start_stop = 1'b1;
    step(4);
    btn_start_stop = 1'b0;
    step(28);
    check("at_0007", digits(), 16'h0007);
    btn_lap = 1'b1;
    step(4);
    check("lap_on",     {15'd0, lap_active}, 16'd1);
    check("lap_frozen", digits(),            16'h0007);
    btn_lap = 1'b0;
    step(76);
    check("lap_still",  digits(),            16'h0007);
    btn_lap = 1'b1;
    step(4);
    check("lap_off",    {15'd0, lap_active}, 16'd0);
    check("lap_live",   digits(),            16'h0028);
    btn_lap = 1'b0;

    // Clear and start_stop together in RUN: clear wins, start dropped
    btn_clear      = 1'b1;
    btn_start_stop = 1'b1;
    step(4);
    check("both_running", {15'd0, running}, 16'd0);
    check("both_digits",  digits(),         16'h0000);
    step(8);
    check("both_idle",    {15'd0, running}, 16'd0);
    check("both_hold",    digits(),         16'h0000);
    btn_clear      = 1'b0;
    btn_start_stop = 1'b0;
    step(2);

    // Lap in IDLE is ignored
    btn_lap = 1'b1;
    step(5);
    check("lap_idle", {15'd0, lap_active}, 16'd0);
    btn_lap = 1'b0;
    step(2);

    // Asynchronous reset at 12.34 with lap active
    btn_start_stop = 1'b1;
    step(4);
    btn_start_stop = 1'b0;
    step(4936);
    check("at_1234", digits(), 16'h1234);
    btn_lap = 1'b1;
    step(4);
    check("lap_1234_on", {15'd0, lap_active}, 16'd1);
    check("lap_1234",    digits(),            16'h1234);
    rst     = 1'b0;
    btn_lap = 1'b0;
    #2;
    check("arst_digits",  digits(),            16'h0000);
    check("arst_running", {15'd0, running},    16'd0);
    check("arst_lap",     {15'd0, lap_active}, 16'd0);
    check("arst_wrap",    {15'd0, wrap},       16'd0);
    step(2);
    rst = 1'b1;
    step(1);
    btn_start_stop = 1'b1;
    step(4);
    check("post_rst_run", {15'd0, running}, 16'd1);
    btn_start_stop = 1'b0;
    step(3);
    check("post_rst_0000", digits(), 16'h0000);
    step(1);
    check("post_rst_0001", digits(), 16'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
